// File: rtl/acc_sequencer.sv
// Sequencer that computes operand x count by driving an external accumulator through clear/add/done phases.
// Optional overflow tracking is enabled by defining ACC_SEQ_OVERFLOW_EN.
module acc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] acc_value,
    output logic [WIDTH-1:0] acc_data,
    output logic             acc_update,
    output logic             acc_clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_result;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ADD exits while r_rem is 1, so exactly count update pulses are issued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = CLEAR;
            CLEAR:   w_nextState = (r_rem != '0) ? ADD : DONE;
            ADD:     if (r_rem == WIDTH'(1)) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_op     <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op  <= operand;
                        r_rem <= count;
                    end
                end
                ADD:     r_rem    <= r_rem - WIDTH'(1);
                DONE:    r_result <= acc_value;
                default: ;
            endcase
        end
    end

    assign acc_data   = r_op;
    assign acc_update = (r_state == ADD);
    assign acc_clear  = (r_state == CLEAR);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign result     = (r_state == DONE) ? acc_value : r_result;

`ifdef ACC_SEQ_OVERFLOW_EN
    logic [WIDTH:0] r_shadowSum;
    logic [WIDTH:0] w_nextSum;
    logic           r_ovf;

    assign w_nextSum = r_shadowSum + {1'b0, r_op};

    // Shadow sum mirrors the accumulator with one extra bit to catch the carry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shadowSum <= '0;
            r_ovf       <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_shadowSum <= '0;
            r_ovf       <= 1'b0;
        end else if (r_state == ADD) begin
            r_shadowSum <= w_nextSum;
            if (w_nextSum[WIDTH]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a behavioural accumulator attached to its control outputs.
// Overflow expectation follows ACC_SEQ_OVERFLOW_EN.
module tb_acc_sequencer;

    localparam int WIDTH = 8;
`ifdef ACC_SEQ_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] accValue;
    logic [WIDTH-1:0] acc_data;
    logic             acc_update;
    logic             acc_clear;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    int vectors;
    int miscompares;

    acc_sequencer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .operand    (operand),
        .count      (count),
        .acc_value  (accValue),
        .acc_data   (acc_data),
        .acc_update (acc_update),
        .acc_clear  (acc_clear),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Accumulator model: clear wins over update, wraps modulo 2^WIDTH.
    initial accValue = 8'hAA;
    always @(posedge clock) begin
        if (acc_clear) accValue <= '0;
        else if (acc_update) accValue <= accValue + acc_data;
    end

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic startOp(input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] cnt);
        start   = 1'b1;
        operand = op;
        count   = cnt;
        waitCycle();
        start = 1'b0;
    endtask

    // Returns the cycle index (accepting edge = start of cycle 1) where done was seen, or -1.
    task automatic waitDone(input int limit, output int cyc, output int updates);
        int n;
        n = 1;
        updates = 0;
        while (done !== 1'b1 && n < limit) begin
            if (acc_update === 1'b1) updates++;
            waitCycle();
            n++;
        end
        cyc = (done === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        waitCycle();
        waitCycle();
        reset = 1'b1;
        vectors++;
        if ({busy, done, acc_update, acc_clear, overflow} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, acc_update, acc_clear, overflow});
        end
        vectors++;
        if (result !== 8'd0 || acc_data !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: result %0d acc_data %0d expected 0 0", result, acc_data);
        end
        waitCycle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        startOp(8'd5, 8'd3);
        vectors++;
        if (acc_clear !== 1'b1 || busy !== 1'b1 || acc_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_clear: clear %b busy %b update %b expected 1 1 0", acc_clear, busy, acc_update);
        end
        for (int c = 2; c <= 4; c++) begin
            waitCycle();
            vectors++;
            if (acc_update !== 1'b1 || acc_clear !== 1'b0 || acc_data !== 8'd5 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL basic_add cycle %0d: update %b clear %b data %0d done %b expected 1 0 5 0",
                         c, acc_update, acc_clear, acc_data, done);
            end
        end
        waitCycle();
        vectors++;
        if (done !== 1'b1 || result !== 8'd15 || acc_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_done: done %b result %0d update %b expected 1 15 0", done, result, acc_update);
        end
        waitCycle();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'd15) begin
            miscompares++;
            $display("[TB] FAIL basic_after: done %b busy %b result %0d expected 0 0 15", done, busy, result);
        end
        waitCycle();
        vectors++;
        if (result !== 8'd15) begin
            miscompares++;
            $display("[TB] FAIL basic_hold: result %0d expected 15", result);
        end
    endtask

    task automatic test_zero_count();
        int cyc;
        int upd;
        startOp(8'd9, 8'd0);
        waitDone(10, cyc, upd);
        vectors++;
        if (cyc !== 2 || upd !== 0) begin
            miscompares++;
            $display("[TB] FAIL zero_timing: done cycle %0d updates %0d expected 2 0", cyc, upd);
        end
        vectors++;
        if (result !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_result: result %0d expected 0", result);
        end
        waitCycle();
    endtask

    task automatic test_overflow();
        int cyc;
        int upd;
        startOp(8'd100, 8'd3);
        waitDone(12, cyc, upd);
        vectors++;
        if (cyc !== 5 || upd !== 3 || result !== 8'd44) begin
            miscompares++;
            $display("[TB] FAIL wrap_result: cycle %0d updates %0d result %0d expected 5 3 44", cyc, upd, result);
        end
        vectors++;
        if (overflow !== EXP_OVF) begin
            miscompares++;
            $display("[TB] FAIL wrap_overflow: got %b expected %b", overflow, EXP_OVF);
        end
        waitCycle();
        startOp(8'd1, 8'd1);
        waitDone(12, cyc, upd);
        vectors++;
        if (cyc !== 3 || result !== 8'd1 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL small_after_wrap: cycle %0d result %0d overflow %b expected 3 1 0", cyc, result, overflow);
        end
        waitCycle();
    endtask

    // start held high with a fresh operand every cycle; dones expected at cycles 4, 9, 14.
    task automatic test_busy_lockout();
        logic [WIDTH-1:0] expRes;
        count = 8'd2;
        start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            operand = 8'(10 + i);
            vectors++;
            if (done !== ((i % 5) == 4)) begin
                miscompares++;
                $display("[TB] FAIL lockout_done cycle %0d: got %b expected %b", i, done, ((i % 5) == 4));
            end
            if ((i % 5) == 4) begin
                expRes = 8'(2 * (10 + i - 4));
                vectors++;
                if (result !== expRes) begin
                    miscompares++;
                    $display("[TB] FAIL lockout_result cycle %0d: got %0d expected %0d", i, result, expRes);
                end
            end
            waitCycle();
        end
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lockout_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_add();
        int cyc;
        int upd;
        startOp(8'd7, 8'd10);
        waitCycle();
        waitCycle();
        waitCycle();
        vectors++;
        if (acc_update !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_pre: update %b expected 1", acc_update);
        end
        reset = 1'b0;
        waitCycle();
        reset = 1'b1;
        vectors++;
        if ({busy, acc_update, acc_clear, done} !== 4'b0 || result !== 8'd0 || acc_data !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_state: flags %b result %0d data %0d expected 0000 0 0",
                     {busy, acc_update, acc_clear, done}, result, acc_data);
        end
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_quiet: done %b busy %b expected 0 0", done, busy);
            end
        end
        startOp(8'd2, 8'd2);
        waitDone(12, cyc, upd);
        vectors++;
        if (cyc !== 4 || result !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL midreset_rerun: cycle %0d result %0d expected 4 4", cyc, result);
        end
        waitCycle();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int upd;
        int n;
        startOp(8'd3, 8'd2);
        waitDone(12, cyc, upd);
        vectors++;
        if (result !== 8'd6) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: result %0d expected 6", result);
        end
        waitCycle();
        startOp(8'd4, 8'd3);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            vectors++;
            if (result !== 8'd6 || busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_hold cycle %0d: result %0d busy %b expected 6 1", n, result, busy);
            end
            waitCycle();
            n++;
        end
        cyc = (done === 1'b1) ? n : -1;
        vectors++;
        if (cyc !== 5 || result !== 8'd12) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: cycle %0d result %0d expected 5 12", cyc, result);
        end
        waitCycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        start   = 1'b0;
        operand = '0;
        count   = '0;
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_busy_lockout();
        test_reset_mid_add();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
